// File: rtl/clk_gen_pkg.sv
// Shared types and ratio helpers for the clk_generator divider.
package clk_gen_pkg;

  localparam int unsigned DIV_W_DEFAULT = 16;
  // Helpers work on a fixed 32-bit argument so any DIV_W up to 32 can use them.
  localparam int unsigned FN_W          = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Ratios below 2 cannot produce both a high and a low phase.
  function automatic logic [FN_W-1:0] div_clamp(input logic [FN_W-1:0] d);
    return (d < FN_W'(2)) ? FN_W'(2) : d;
  endfunction

  // ceil(d/2), one bit wider than the argument so d = all-ones cannot overflow.
  function automatic logic [FN_W:0] high_cycles(input logic [FN_W-1:0] d);
    return ({1'b0, d} + (FN_W+1)'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_gen_lock_mon.sv
// Counts completed sys_clk periods and raises locked once enough have elapsed.
module clk_gen_lock_mon
  import clk_gen_pkg::*;
#(
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic period_done_i,
  input  logic clear_i,
  output logic locked_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_PERIODS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // Saturating count; clear has priority over a coincident period pulse.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (clear_i) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (period_done_i && (cnt_q != CNT_W'(LOCK_PERIODS))) begin
      cnt_d    = cnt_q + CNT_W'(1);
      locked_d = (cnt_d == CNT_W'(LOCK_PERIODS));
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/clk_generator.sv
// Programmable integer clock divider with registered output, edge strobes,
// boundary-synchronous reconfiguration and a lock indicator.
module clk_generator
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W        = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV  = 2,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             sys_clk,
  output logic             sys_clk_rise,
  output logic             sys_clk_fall,
  output logic             locked
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(div_clamp(FN_W'(DEFAULT_DIV)));

  run_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             sys_clk_q, sys_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [DIV_W:0]   hi_c;
  logic             wrap_c;
  logic             period_done_c;
  logic             lock_clr_c;

  assign hi_c   = (DIV_W+1)'(high_cycles(FN_W'(cur_div_q)));
  assign wrap_c = (state_q == ST_RUN) && (cnt_q == (cur_div_q - DIV_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_div_q <= RST_DIV;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      sys_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      sys_clk_q <= sys_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // A pending ratio is only applied when a period starts, so a load coinciding
  // with a boundary stays pending (busy_q still low) until the next one.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_div_d     = cur_div_q;
    pend_d        = pend_q;
    busy_d        = busy_q;
    sys_clk_d     = sys_clk_q;
    period_done_c = 1'b0;
    lock_clr_c    = 1'b0;

    if (cfg_load) begin
      pend_d = DIV_W'(div_clamp(FN_W'(cfg_div)));
      busy_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          sys_clk_d  = 1'b1;
          lock_clr_c = 1'b1;
          if (busy_q) begin
            cur_div_d = pend_q;
            busy_d    = cfg_load;
          end
        end
      end
      ST_RUN: begin
        if (wrap_c) begin
          cnt_d = '0;
          if (!en) begin
            state_d    = ST_IDLE;
            sys_clk_d  = 1'b0;
            lock_clr_c = 1'b1;
          end else begin
            sys_clk_d = 1'b1;
            if (busy_q) begin
              cur_div_d  = pend_q;
              busy_d     = cfg_load;
              lock_clr_c = 1'b1;
            end else begin
              period_done_c = 1'b1;
            end
          end
        end else begin
          cnt_d     = cnt_q + DIV_W'(1);
          sys_clk_d = ({1'b0, cnt_d} < hi_c);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes derive from the registered edge, so they can never repeat back to back.
  assign rise_d = ~sys_clk_q & sys_clk_d;
  assign fall_d = sys_clk_q & ~sys_clk_d;

  clk_gen_lock_mon #(
    .LOCK_PERIODS(LOCK_PERIODS)
  ) u_lock_mon (
    .clk          (clk),
    .rst          (rst),
    .period_done_i(period_done_c),
    .clear_i      (lock_clr_c),
    .locked_o     (locked)
  );

  assign cfg_busy     = busy_q;
  assign cur_div      = cur_div_q;
  assign sys_clk      = sys_clk_q;
  assign sys_clk_rise = rise_q;
  assign sys_clk_fall = fall_q;

endmodule

// File: tb/tb_clk_generator.sv
// Directed bench for clk_generator: vector table for start-up and first
// reconfiguration, then hand-written sequences for the multi-cycle corners.
module tb_clk_generator;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] cfg_div;
  logic        cfg_load;
  logic        cfg_busy;
  logic [15:0] cur_div;
  logic        sys_clk;
  logic        sys_clk_rise;
  logic        sys_clk_fall;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  clk_generator #(
    .DIV_W       (16),
    .DEFAULT_DIV (2),
    .LOCK_PERIODS(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_div     (cfg_div),
    .cfg_load    (cfg_load),
    .cfg_busy    (cfg_busy),
    .cur_div     (cur_div),
    .sys_clk     (sys_clk),
    .sys_clk_rise(sys_clk_rise),
    .sys_clk_fall(sys_clk_fall),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] div;
    logic        sys;
    logic        rise;
    logic        fall;
    logic        lock;
    logic        busy;
    logic [15:0] cur;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic l, input logic [15:0] d);
    en       = e;
    cfg_load = l;
    cfg_div  = d;
  endtask

  task automatic chk_out(input string nm, input logic s, input logic r, input logic f,
                         input logic lk, input logic b, input logic [15:0] c);
    chk({nm, " sys_clk"},  32'(sys_clk),      32'(s));
    chk({nm, " rise"},     32'(sys_clk_rise), 32'(r));
    chk({nm, " fall"},     32'(sys_clk_fall), 32'(f));
    chk({nm, " locked"},   32'(locked),       32'(lk));
    chk({nm, " cfg_busy"}, 32'(cfg_busy),     32'(b));
    chk({nm, " cur_div"},  32'(cur_div),      32'(c));
  endtask

  // Load a ratio, then wait (bounded) for the boundary where it takes effect.
  task automatic apply_cfg(input logic [15:0] d, input logic [15:0] exp_cur, input string nm);
    int n;
    drive(1'b1, 1'b1, d);
    tick();
    chk({nm, " busy after load"}, 32'(cfg_busy), 32'(1));
    drive(1'b1, 1'b0, 16'd0);
    n = 0;
    while (cfg_busy && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " apply timeout"}, 32'(n < 40), 32'(1));
    chk({nm, " cur_div"},       32'(cur_div), 32'(exp_cur));
    chk({nm, " apply rise"},    32'(sys_clk_rise), 32'(1));
    chk({nm, " apply unlock"},  32'(locked), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en  ld  div    sys r  f  lk b  cur
    tbl[0]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[1]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[2]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[3]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[6]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[8]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[10] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5};
    tbl[11] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    tbl[12] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    tbl[13] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5};
    tbl[14] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
    tbl[15] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5};

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd0);
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

    // Start-up at D=2, lock, then a mid-period load of 5 (cycles 1..16).
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].div);
      tick();
      chk_out($sformatf("v%0d", i + 1), tbl[i].sys, tbl[i].rise, tbl[i].fall,
              tbl[i].lock, tbl[i].busy, tbl[i].cur);
    end
    drive(1'b1, 1'b0, 16'd0);

    // D=5 runs 1,1,1,0,0 from cycle 11; lock returns at the rise of cycle 31.
    for (int k = 17; k <= 31; k++) begin
      int ph;
      ph = (k - 11) % 5;
      tick();
      chk_out($sformatf("d5 c%0d", k), ph < 3, ph == 0, ph == 3, k >= 31, 1'b0, 16'd5);
    end

    // Back-to-back loads before any boundary: the last one wins.
    drive(1'b1, 1'b1, 16'd7);
    tick();
    drive(1'b1, 1'b1, 16'd3);
    tick();
    chk("b2b busy", 32'(cfg_busy), 32'(1));
    chk("b2b cur held", 32'(cur_div), 32'(5));
    drive(1'b1, 1'b0, 16'd0);
    for (int n = 0; n < 40 && cfg_busy; n++) tick();
    chk("b2b cur_div", 32'(cur_div), 32'(3));
    chk("b2b rise", 32'(sys_clk_rise), 32'(1));
    tick();
    chk("d3 ph1", 32'(sys_clk), 32'(1));
    tick();
    chk("d3 ph2", 32'(sys_clk), 32'(0));
    chk("d3 fall", 32'(sys_clk_fall), 32'(1));

    apply_cfg(16'd1, 16'd2, "clamp1");
    apply_cfg(16'd4, 16'd4, "load4a");
    apply_cfg(16'd0, 16'd2, "clamp0");
    apply_cfg(16'd4, 16'd4, "load4b");

    // Lock at D=4, then drop en while sys_clk is high.
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("d4 lock c%0d", k), 32'(locked), 32'(k == 16));
    end
    drive(1'b0, 1'b0, 16'd0);
    tick();
    chk_out("dis ph1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    tick();
    chk_out("dis ph2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4);
    tick();
    chk_out("dis ph3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("idle %0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
    end

    // A load while disabled applies on restart, which rises immediately.
    drive(1'b0, 1'b1, 16'd6);
    tick();
    chk_out("idle load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
    drive(1'b1, 1'b0, 16'd0);
    tick();
    chk_out("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6);
    tick();
    chk("d6 ph1", 32'(sys_clk), 32'(1));

    // Async reset in the high phase with a ratio pending.
    drive(1'b1, 1'b1, 16'd9);
    tick();
    chk("pre-rst busy", 32'(cfg_busy), 32'(1));
    chk("pre-rst sys", 32'(sys_clk), 32'(1));
    drive(1'b1, 1'b0, 16'd0);
    #3 rst = 1'b1;
    #1;
    chk_out("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    #10;
    chk_out("rst held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    rst = 1'b0;
    tick();
    chk_out("post-rst start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("post-rst cur c%0d", k), 32'(cur_div), 32'(2));
      chk($sformatf("post-rst busy c%0d", k), 32'(cfg_busy), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
